// File: rtl/imem_boot_loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
package imem_boot_loader_pkg;
    localparam int IMEM_DEPTH_WORDS_DEF = 256;
    localparam int ADDR_WIDTH_DEF       = 32;
    localparam int WORD_BYTES           = 4;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    // States in which the loader still consumes stream bytes.
    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
    endfunction
endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [7:0]            byte_data_i;
    logic                  byte_valid_i;
    logic                  byte_ready_o;
    logic                  imem_we_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic [31:0]           imem_wdata_o;

    modport slave (
        input  byte_data_i, byte_valid_i,
        output byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );

    modport master (
        output byte_data_i, byte_valid_i,
        input  byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );
endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Packs accepted stream bytes little-endian into 32-bit words; word_valid_o
// pulses combinationally in the cycle the 4th byte is handshaken.
module byte_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    input  logic        ready_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;
    logic        accept;

    assign accept = valid_i & ready_i;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (accept) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    sr_d[7:0]   = byte_i;
                2'd1:    sr_d[15:8]  = byte_i;
                2'd2:    sr_d[23:16] = byte_i;
                default: sr_d[31:24] = byte_i;
            endcase
        end
    end

    // The word is taken from the next-state value so it is usable on the 4th byte.
    assign word_o       = sr_d;
    assign word_valid_o = accept && (cnt_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives LEN, N data words and an XOR checksum, writes the words
// to instruction memory and releases the core only after the checksum matches.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int IMEM_DEPTH_WORDS = IMEM_DEPTH_WORDS_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    imem_boot_loader_if.slave  bus,
    output logic               core_rst_o,
    output logic               done_o,
    output logic               error_o
);
    // One extra bit so N == depth is representable.
    localparam int IDXW = $clog2(IMEM_DEPTH_WORDS) + 1;

    loader_state_t         state_q, state_d;
    logic [IDXW-1:0]       len_q, len_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [31:0]           acc_q, acc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  core_rst_q, core_rst_d;

    logic [31:0] word;
    logic        word_valid;

    byte_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (bus.byte_data_i),
        .valid_i      (bus.byte_valid_i),
        .ready_i      (ready_q),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_LEN: if (word_valid) begin
                len_d = word[IDXW-1:0];
                idx_d = '0;
                acc_d = '0;
                if (word == 32'd0)                  state_d = S_CSUM;
                else if (word > IMEM_DEPTH_WORDS)   state_d = S_ERR;
                else                                state_d = S_DATA;
            end
            S_DATA: if (word_valid) begin
                we_d    = 1'b1;
                addr_d  = ADDR_WIDTH'({idx_q, 2'b00});
                wdata_d = word;
                acc_d   = acc_q ^ word;
                idx_d   = idx_q + 1'b1;
                if (idx_q == len_q - 1'b1) state_d = S_CSUM;
            end
            S_CSUM: if (word_valid) begin
                state_d = (word == acc_q) ? S_DONE : S_ERR;
            end
            default: ;
        endcase
        // Status outputs are registered from the next state so they change together.
        ready_d    = accepts_bytes(state_d);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        core_rst_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LEN;
            len_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.imem_we_o    = we_q;
    assign bus.imem_addr_o  = addr_q;
    assign bus.imem_wdata_o = wdata_q;
    assign core_rst_o       = core_rst_q;
    assign done_o           = done_q;
    assign error_o          = err_q;
endmodule
